// File: rtl/gen_pipe_stages.sv
// Valid/ready register pipeline of DEPTH slices, one slice per generate iteration.
// Optional per-slice parity bit that travels with the data: define GEN_PIPE_PARITY_EN.
module gen_pipe_stages #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         out_parity
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  // Element k of each chain is the input of slice k; element DEPTH is the pipe output.
  logic [DEPTH:0]   vld_chain;
  logic [WIDTH-1:0] data_chain [DEPTH+1];
  logic [DEPTH:0]   rdy;

  assign vld_chain[0]  = in_valid;
  assign data_chain[0] = in_data;

  // Ready ripples backwards from the sink; computed in one process to keep the chain acyclic.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      rdy[i-1] = !vld_chain[i] | rdy[i];
    end
  end

`ifdef GEN_PIPE_PARITY_EN
  logic [DEPTH:0] par_chain;
  assign par_chain[0] = ^in_data;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (rdy[k]) begin
        valid_d = vld_chain[k];
        data_d  = data_chain[k];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign vld_chain[k+1]  = valid_q;
    assign data_chain[k+1] = data_q;

`ifdef GEN_PIPE_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
      parity_d = parity_q;
      if (rdy[k]) parity_d = par_chain[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= parity_d;
    end

    assign par_chain[k+1] = parity_q;
`endif
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld_chain[i]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_chain[DEPTH];
  assign out_data  = data_chain[DEPTH];

`ifdef GEN_PIPE_PARITY_EN
  assign out_parity = par_chain[DEPTH];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_gen_pipe_stages.sv
// Self-checking bench for gen_pipe_stages: queue scoreboard plus arithmetic latency model.
module tb_gen_pipe_stages;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic                       out_parity;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  always #5 clk = ~clk;

  gen_pipe_stages #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .out_parity(out_parity)
  );

  function automatic logic exp_par(input logic [WIDTH-1:0] d);
`ifdef GEN_PIPE_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Called after the negedge sample: records the transfers of the coming edge in the model.
  task automatic tick();
    logic push, pop;
    logic [WIDTH-1:0] d;
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    d    = in_data;
    @(posedge clk);
    if (pop && q.size() > 0) void'(q.pop_front());
    if (push) q.push_back(d);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0 || in_ready !== 1'b1 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: ov=%b od=%h occ=%0d ir=%b par=%b, want 0 00 0 1 0", out_valid, out_data, occupancy, in_ready, out_parity);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 3) begin
      errors++;
      $display("FAIL reset_prefill_occ: got %0d want 3", occupancy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0 || in_ready !== 1'b1 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: ov=%b od=%h occ=%0d ir=%b par=%b, want 0 00 0 1 0", out_valid, out_data, occupancy, in_ready, out_parity);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic exp_v;
    out_ready = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      if (t < 16) begin
        in_valid = 1'b1; in_data = WIDTH'(t + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      exp_v = (t >= DEPTH) && (t - DEPTH < 16);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== exp_v) begin
        errors++;
        $display("FAIL stream_flags t=%0d: ir=%b ov=%b, want ir=1 ov=%b", t, in_ready, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_data !== WIDTH'(t - DEPTH + 1)) begin
          errors++;
          $display("FAIL stream_data t=%0d: got %h want %h", t, out_data, WIDTH'(t - DEPTH + 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    int n, got;
    n = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 8'hA0 + WIDTH'(n);
      @(negedge clk);
      checks++;
      if (in_ready !== (n < DEPTH)) begin
        errors++;
        $display("FAIL fill_ready c=%0d: got %b want %b", c, in_ready, (n < DEPTH));
      end
      if (in_ready) n++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (n !== DEPTH || occupancy !== DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL fill_full: accepts=%0d occ=%0d ir=%b ov=%b od=%h, want 4 4 0 1 a0", n, occupancy, in_ready, out_valid, out_data);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && got < DEPTH; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_data !== 8'hA0 + WIDTH'(got)) begin
          errors++;
          $display("FAIL drain_order: got %h want %h", out_data, 8'hA0 + WIDTH'(got));
        end
        got++;
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (got !== DEPTH || occupancy !== 0) begin
      errors++;
      $display("FAIL drain_done: words=%0d occ=%0d, want 4 0", got, occupancy);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + WIDTH'(i);
      @(negedge clk);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 8'hB0 + WIDTH'(DEPTH + c);
      @(negedge clk);
      checks++;
      if (occupancy !== DEPTH || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hB0 + WIDTH'(c)) begin
        errors++;
        $display("FAIL full_pushpop c=%0d: occ=%0d ir=%b ov=%b od=%h, want 4 1 1 %h", c, occupancy, in_ready, out_valid, out_data, 8'hB0 + WIDTH'(c));
      end
      tick();
    end
    drain();
    @(negedge clk);
    checks++;
    if (q.size() != 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL full_drain: model=%0d occ=%0d, want 0 0", q.size(), occupancy);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic prev_stall, held, exp_rdy;
    logic [WIDTH-1:0] prev_data;
    prev_stall = 1'b0; held = 1'b0; prev_data = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!held) begin
        in_valid = ~in_valid;
        if (in_valid) in_data = WIDTH'($urandom);
      end
      out_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      exp_rdy = !(q.size() == DEPTH && !out_ready);
      checks++;
      if (occupancy !== q.size() || occupancy > DEPTH || in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bubble_occ c=%0d: occ=%0d ir=%b, want occ=%0d ir=%b", c, occupancy, in_ready, q.size(), exp_rdy);
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || out_data !== q[0] || out_parity !== exp_par(q[0])) begin
          errors++;
          $display("FAIL bubble_data c=%0d: od=%h par=%b, model depth %0d", c, out_data, out_parity, q.size());
        end
      end else if (q.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bubble_empty c=%0d: ov=%b want 0", c, out_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL bubble_stable c=%0d: ov=%b od=%h, want 1 %h", c, out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      held       = in_valid && !in_ready;
      tick();
    end
    drain();
    @(negedge clk);
    checks++;
    if (q.size() != 0 || occupancy !== 0) begin
      errors++;
      $display("FAIL bubble_drain: model=%0d occ=%0d, want 0 0", q.size(), occupancy);
    end
    tick();
  endtask

  task automatic test_parity();
    logic [WIDTH-1:0] exp_d [2];
    logic             exp_p [2];
    int got;
    exp_d[0] = 8'h07; exp_d[1] = 8'h03;
`ifdef GEN_PIPE_PARITY_EN
    exp_p[0] = 1'b1; exp_p[1] = 1'b0;
`else
    exp_p[0] = 1'b0; exp_p[1] = 1'b0;
`endif
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 2; c++) begin
      in_valid = (c < 2);
      in_data  = (c < 2) ? exp_d[c] : '0;
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_data !== exp_d[got] || out_parity !== exp_p[got]) begin
          errors++;
          $display("FAIL parity: od=%h par=%b, want %h %b", out_data, out_parity, exp_d[got], exp_p[got]);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL parity_timeout: words seen %0d want 2", got);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill_stall();
    test_full_push_pop();
    test_bubbles();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
